// File: rtl/ltl_automaton_pkg.sv
// Shared types for the programmable STE automaton engine: start types,
// config-port selectors and the streaming FSM states.
package ltl_automaton_pkg;

   typedef enum logic [1:0] {
      ST_NONE = 2'd0,
      ST_SOD  = 2'd1,
      ST_ALL  = 2'd2
   } start_type_e;

   typedef enum logic [1:0] {
      CFG_MATCH = 2'd0,
      CFG_PRED  = 2'd1,
      CFG_ATTR  = 2'd2
   } cfg_sel_e;

   typedef enum logic [1:0] {
      S_CFG    = 2'd0,
      S_SOD    = 2'd1,
      S_STREAM = 2'd2
   } state_e;

endpackage

// File: rtl/ltl_report_fifo.sv
// Report FIFO: synchronous, active-low reset, head visible combinationally
// from storage; a push while full is only taken together with a pop.
module ltl_report_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_valid,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = i_pop & (r_count != '0);
   assign w_push = i_push & ((r_count != CW'(DEPTH)) | w_pop);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and count alone
   // decide which entries are valid, so clearing the array buys nothing.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= i_push_data;
   end

   assign o_head  = r_mem[r_rptr];
   assign o_valid = (r_count != '0);
   assign o_count = r_count;

endmodule

// File: rtl/prog_ltl_automaton.sv
// Runtime-programmable homogeneous STE automaton: config port loads match
// tables, edges and attributes; a symbol stream drives the active vector.
module prog_ltl_automaton
   import ltl_automaton_pkg::*;
#(
   parameter int N_STE     = 16,
   parameter int SYM_W     = 8,
   parameter int RPT_DEPTH = 8,
   parameter int IDX_W     = 32,
   localparam int STE_W = $clog2(N_STE),
   localparam int CNT_W = $clog2(RPT_DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_run,
   input  logic             i_cfg_we,
   input  logic [1:0]       i_cfg_sel,
   input  logic [STE_W-1:0] i_cfg_ste,
   input  logic [SYM_W-1:0] i_cfg_sym,
   input  logic [N_STE-1:0] i_cfg_data,
   input  logic             i_sym_valid,
   input  logic [SYM_W-1:0] i_sym_data,
   input  logic             i_sym_last,
   output logic             o_sym_ready,
   output logic             o_rpt_valid,
   input  logic             i_rpt_ready,
   output logic [N_STE-1:0] o_rpt_vec,
   output logic [IDX_W-1:0] o_rpt_idx,
   output logic [N_STE-1:0] o_active,
   output logic             o_busy
);

   localparam int N_SYM  = 2 ** SYM_W;
   localparam int FIFO_W = N_STE + IDX_W;

   state_e           r_state;
   state_e           w_state_nxt;
   logic [N_STE-1:0] r_active;
   logic [IDX_W-1:0] r_sym_idx;
   logic [N_SYM-1:0] r_match [N_STE];
   logic [N_STE-1:0] r_pred  [N_STE];
   logic [1:0]       r_start [N_STE];
   logic [N_STE-1:0] r_rpt_en;

   logic             w_accept;
   logic             w_cfg_wr;
   logic [2:0]       w_attr;
   logic [N_STE-1:0] w_prev;
   logic [N_STE-1:0] w_active_nxt;
   logic [N_STE-1:0] w_rpt_vec;
   logic [CNT_W-1:0] w_fifo_count;
   logic [FIFO_W-1:0] w_fifo_head;

   assign o_sym_ready = (r_state != S_CFG) & i_run & (w_fifo_count < CNT_W'(RPT_DEPTH));
   assign w_accept    = i_sym_valid & o_sym_ready;
   assign w_cfg_wr    = i_cfg_we & (r_state == S_CFG);
   assign w_attr      = 3'(i_cfg_data);

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      if (!i_run) begin
         w_state_nxt = S_CFG;
      end else begin
         case (r_state)
            S_CFG:    w_state_nxt = S_SOD;
            S_SOD:    if (w_accept && !i_sym_last) w_state_nxt = S_STREAM;
            S_STREAM: if (w_accept && i_sym_last)  w_state_nxt = S_SOD;
            default:  w_state_nxt = S_CFG;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) r_state <= S_CFG;
      else          r_state <= w_state_nxt;
   end

   // S_SOD is only ever entered from config or after a last symbol, so the
   // previous stream's active vector must not enable anything there.
   always_comb begin
      w_prev       = (r_state == S_SOD) ? '0 : r_active;
      w_active_nxt = '0;
      for (int i = 0; i < N_STE; i++) begin
         w_active_nxt[i] = ((r_start[i] == ST_ALL)
                            | ((r_start[i] == ST_SOD) & (r_state == S_SOD))
                            | (|(w_prev & r_pred[i])))
                           & r_match[i][i_sym_data];
      end
      w_rpt_vec = w_active_nxt & r_rpt_en;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_active  <= '0;
         r_sym_idx <= '0;
      end else if (!i_run) begin
         r_active  <= '0;
         r_sym_idx <= '0;
      end else if (w_accept) begin
         r_active  <= w_active_nxt;
         r_sym_idx <= i_sym_last ? '0 : r_sym_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         for (int i = 0; i < N_STE; i++) begin
            r_match[i] <= '0;
            r_pred[i]  <= '0;
            r_start[i] <= ST_NONE;
         end
         r_rpt_en <= '0;
      end else if (w_cfg_wr) begin
         case (cfg_sel_e'(i_cfg_sel))
            CFG_MATCH: r_match[i_cfg_ste][i_cfg_sym] <= i_cfg_data[0];
            CFG_PRED:  r_pred[i_cfg_ste] <= i_cfg_data;
            CFG_ATTR: begin
               r_start[i_cfg_ste]  <= w_attr[1:0];
               r_rpt_en[i_cfg_ste] <= w_attr[2];
            end
            default: ;
         endcase
      end
   end

   ltl_report_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (RPT_DEPTH)
   ) u_rpt_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_reset),
      .i_push      (w_accept & (|w_rpt_vec)),
      .i_push_data ({w_rpt_vec, r_sym_idx}),
      .i_pop       (i_rpt_ready),
      .o_head      (w_fifo_head),
      .o_valid     (o_rpt_valid),
      .o_count     (w_fifo_count)
   );

   assign {o_rpt_vec, o_rpt_idx} = w_fifo_head;
   assign o_active = r_active;
   assign o_busy   = (r_state != S_CFG);

endmodule

// File: doc/prog_ltl_automaton.md
Name: prog_ltl_automaton

Overview:
- Runtime-programmable, homogeneous STE automaton engine for the runtime-monitor clusters. Replaces per-property hard-wired automata.
- STE count and symbol width are parameters. The match table, edge set, start type and report flag of each STE are loaded through a config port.
- Consumes a symbol stream over a valid/ready handshake. Emits report events (active-report vector plus symbol index) through a small report FIFO, with backpressure to the symbol source.

Parameters:
- N_STE, 16, number of STEs (2..64).
- SYM_W, 8, symbol width; each STE match table has 2^SYM_W entries.
- RPT_DEPTH, 8, report FIFO depth (power of 2, >=2).
- IDX_W, 32, symbol index counter width.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- run  in  1  1 = streaming mode, 0 = configuration mode.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  2  0 = match bit, 1 = predecessor row, 2 = STE attributes.
- cfg_ste  in  $clog2(N_STE)  target STE.
- cfg_sym  in  SYM_W  symbol address (cfg_sel=0 only).
- cfg_data  in  N_STE  write data.
- sym_valid  in  1  symbol offered.
- sym_data  in  SYM_W  symbol.
- sym_last  in  1  last symbol of the current stream.
- sym_ready  out  1  symbol accepted when sym_valid & sym_ready.
- rpt_valid  out  1  FIFO head valid.
- rpt_ready  in  1  consumer pops the head.
- rpt_vec  out  N_STE  active & report_en at the reporting symbol.
- rpt_idx  out  IDX_W  index of the reporting symbol within its stream.
- active  out  N_STE  current active-state vector.
- busy  out  1  state != S_CFG.

Behaviour:
- Reset (reset==0 at posedge) clears everything:
  - state=S_CFG; active=0; sym_idx=0; FIFO emptied; rpt_valid=0; sym_ready=0; busy=0.
  - All match bits, predecessor rows, start types and report_en are cleared.
  - Reset mid-stream drops pending reports.
- Config writes take effect only when state==S_CFG; otherwise they are ignored.
  - sel0: match[cfg_ste][cfg_sym] <= cfg_data[0].
  - sel1: pred[cfg_ste] <= cfg_data (bit j = edge from STE j into cfg_ste).
  - sel2: start_type[cfg_ste] <= cfg_data[1:0] (0 none, 1 start-of-data, 2 all-input, 3 reserved = none); report_en[cfg_ste] <= cfg_data[2].
- FSM states S_CFG, S_SOD, S_STREAM:
  - S_CFG, run=1 -> S_SOD.
  - S_SOD, accept -> S_STREAM, or stay in S_SOD if sym_last.
  - S_STREAM, accept with sym_last -> S_SOD, and sym_idx <= 0.
  - Any state, run=0 -> S_CFG, active <= 0, sym_idx <= 0. FIFO is retained and stays drainable.
  - run=0 has priority over a same-cycle accept; no symbol is accepted in that cycle.
- sym_ready = (state != S_CFG) & run & (fifo_count < RPT_DEPTH).
  - Uses registered count only: a pop on a full FIFO does not raise sym_ready in the same cycle.
- On accept, for each STE i:
  - en_i = (start_type_i==2) | (start_type_i==1 & state==S_SOD) | |(active & pred_i).
  - active_i <= en_i & match[i][sym_data].
  - Latency is 1 cycle: active reflects the symbol on the edge after acceptance.
- sym_last accept: active is still updated normally for that symbol. The next accepted symbol sees active=0 and start-of-data re-armed.
- Report push: if the accept yields nxt = active_next & report_en != 0, push {nxt, sym_idx} on the same edge.
  - sym_idx is the pre-increment value; the first symbol of a stream has index 0.
  - sym_idx increments per accept and wraps at 2^IDX_W.
- FIFO behaviour:
  - Simultaneous push and pop is legal when non-empty.
  - Pop on empty is ignored.
  - rpt_vec/rpt_idx show the head combinationally from storage and hold while rpt_valid & ~rpt_ready.

Decomposition:
- Package ltl_automaton_pkg holds: start_type_e {ST_NONE, ST_SOD, ST_ALL}; cfg_sel_e {CFG_MATCH, CFG_PRED, CFG_ATTR}; fsm state_e {S_CFG, S_SOD, S_STREAM}.
- One sub-module: ltl_report_fifo (synchronous, active-low reset, count output, width N_STE+IDX_W).

Test Plan:
- Basic chain:
  - Program STE0 = SOD, match 0x0A. Program STE1 = pred{STE0}, match 0x0B, report_en.
  - Stream 0x0A, 0x0B(last) -> one report: rpt_vec=0x0002, rpt_idx=1. active=0x0001 then 0x0002.
- Start-type semantics:
  - STE0 = SOD matching 0x0A. Stream 0x0B, 0x0A -> STE0 never active.
  - Set STE0 = all-input. Same stream -> active=0x0001 after the second symbol.
- Backpressure (RPT_DEPTH=2, rpt_ready=0, every symbol reports):
  - After 2 accepts, sym_ready=0; the third symbol is held.
  - Raise rpt_ready for 1 cycle -> sym_ready returns the cycle after the pop.
  - Reports come out in order with idx 0, 1, 2.
- Stream restart:
  - Chain test with sym_last on 0x0A, then 0x0B -> no report.
  - Next 0x0A, 0x0B -> report idx=1.
- Config lockout:
  - cfg_we during S_STREAM changing STE1 match -> behaviour unchanged.
  - After run=0, active=0 and pending FIFO entries are still poppable.
- Reset mid-stream:
  - reset=0 for 1 cycle with FIFO holding 1 entry -> rpt_valid=0, active=0, busy=0.
  - Chain re-run without reprogramming -> no reports, because tables are cleared.
